// File: rtl/encoder_drain_seq.sv
// encoder_drain_seq: sequential priority encoder that drains a request vector.
// It accepts an IN_W-bit vector over a valid/ready handshake and then emits
// the index of every set bit, one beat per cycle, in priority order.
// Optional feature macro: ENC_ZERO_ERR_EN. When it is defined, an accepted
// all-zero vector produces one flagged beat on the err port.
module encoder_drain_seq #(
    parameter int IN_W      = 8,
    parameter int MSB_FIRST = 0,
    localparam int OUT_W    = $clog2(IN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
`ifdef ENC_ZERO_ERR_EN
    ,
    output logic             err
`endif
);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [IN_W-1:0] pend, pend_nxt;
    logic            zflag, zflag_nxt;
    logic            accept, xfer;
    logic [IN_W-1:0] bit_sel;

    // Index of the highest-priority set bit; later loop hits overwrite earlier
    // ones, so the scan runs from the lowest-priority end.
    function automatic logic [OUT_W-1:0] pick(input logic [IN_W-1:0] v);
        logic [OUT_W-1:0] r;
        int               j;
        r = '0;
        for (int i = 0; i < IN_W; i++) begin
            j = (MSB_FIRST != 0) ? i : (IN_W - 1 - i);
            if (v[j]) r = OUT_W'(j);
        end
        return r;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic single(input logic [IN_W-1:0] v);
        return (v != '0) && ((v & (v - IN_W'(1))) == '0);
    endfunction

    // Outputs depend only on registered state; out_ready->in_ready is the
    // single combinational path, which gives zero-bubble vector reload.
    assign out_valid = (state == DRAIN);
    assign busy      = (state == DRAIN);
    assign out_idx   = pick(pend);
    assign out_last  = (state == DRAIN) && (zflag || single(pend));
    assign in_ready  = rst_n && ((state == IDLE) || (out_valid && out_ready && out_last));
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign bit_sel   = IN_W'(1) << out_idx;
`ifdef ENC_ZERO_ERR_EN
    assign err       = (state == DRAIN) && zflag;
`endif

    // Next-state: retire the current bit on a transfer, then let a newly
    // accepted vector override everything (reload in the last-beat cycle).
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        zflag_nxt = zflag;
        if (xfer) begin
            pend_nxt = pend & ~bit_sel;
            if (out_last) begin
                state_nxt = IDLE;
                zflag_nxt = 1'b0;
            end
        end
        if (accept) begin
            pend_nxt  = in_vec;
            zflag_nxt = 1'b0;
            if (in_vec != '0) begin
                state_nxt = DRAIN;
            end else begin
`ifdef ENC_ZERO_ERR_EN
                state_nxt = DRAIN;
                zflag_nxt = 1'b1;
`else
                state_nxt = IDLE;
`endif
            end
        end
    end

    // State registers; reset discards any pending bits so no stale beats survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            zflag <= 1'b0;
        end else begin
            state <= state_nxt;
            pend  <= pend_nxt;
            zflag <= zflag_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_drain_seq.sv
// Bench for encoder_drain_seq: three instances (8-bit LSB-first, 16-bit
// LSB-first, 8-bit MSB-first) checked every cycle against a queue model of
// the beats each vector must produce, plus literal beat-sequence checks.
module tb_encoder_drain_seq;

    logic        clk, rst_n, out_ready;
    logic [15:0] in_vec;
    logic        iv_a, iv_b, iv_c;
    logic        ir_a, ir_b, ir_c;
    logic        ov_a, ov_b, ov_c;
    logic [2:0]  idx_a, idx_c;
    logic [3:0]  idx_b;
    logic        last_a, last_b, last_c;
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // model: per instance a ring of expected beats (idx | last<<8 | err<<9)
    int mq [3][0:63];
    int mh [3];
    int mt [3];
    int loga[$], logb[$], logc[$];
    int acc_cyc_a[$], beat_cyc_a[$];

    encoder_drain_seq #(.IN_W(8), .MSB_FIRST(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_a), .in_ready(ir_a), .in_vec(in_vec[7:0]),
        .out_valid(ov_a), .out_ready(out_ready), .out_idx(idx_a), .out_last(last_a), .busy(busy_a)
`ifdef ENC_ZERO_ERR_EN
        , .err(err_a)
`endif
    );
    encoder_drain_seq #(.IN_W(16), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b), .in_vec(in_vec),
        .out_valid(ov_b), .out_ready(out_ready), .out_idx(idx_b), .out_last(last_b), .busy(busy_b)
`ifdef ENC_ZERO_ERR_EN
        , .err(err_b)
`endif
    );
    encoder_drain_seq #(.IN_W(8), .MSB_FIRST(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_c), .in_ready(ir_c), .in_vec(in_vec[7:0]),
        .out_valid(ov_c), .out_ready(out_ready), .out_idx(idx_c), .out_last(last_c), .busy(busy_c)
`ifdef ENC_ZERO_ERR_EN
        , .err(err_c)
`endif
    );
`ifndef ENC_ZERO_ERR_EN
    assign err_a = 1'b0;
    assign err_b = 1'b0;
    assign err_c = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One instance, one cycle: compare against the model, then advance it.
    task automatic chk(input int d, input logic ov, input logic ir, input int idx,
                       input logic lst, input logic bsy, input logic er, input logic iv,
                       input logic [15:0] vec, input int w, input int msb);
        int n, e, cnt;
        n = mt[d] - mh[d];
        if (!rst_n) begin
            ck("rst_out_valid", ov, 0);
            ck("rst_out_idx", idx, 0);
            ck("rst_out_last", lst, 0);
            ck("rst_busy", bsy, 0);
            ck("rst_in_ready", ir, 0);
            ck("rst_err", er, 0);
            mh[d] = 0;
            mt[d] = 0;
        end else begin
            ck("out_valid", ov, n > 0);
            ck("busy", bsy, n > 0);
            ck("in_ready", ir, (n == 0) || (n == 1 && out_ready));
            if (n > 0) begin
                e = mq[d][mh[d] % 64];
                ck("out_idx", idx, e & 255);
                ck("out_last", lst, (e >> 8) & 1);
                ck("err", er, (e >> 9) & 1);
                if (out_ready) mh[d]++;
            end
            if (ov && out_ready) begin
                case (d)
                    0: begin loga.push_back(idx); beat_cyc_a.push_back(cyc); end
                    1: logb.push_back(idx);
                    default: logc.push_back(idx);
                endcase
            end
            if (iv && ir) begin
                cnt = 0;
                for (int k = 0; k < w; k++) begin
                    int b;
                    b = (msb != 0) ? (w - 1 - k) : k;
                    if (vec[b]) begin
                        mq[d][mt[d] % 64] = b;
                        mt[d]++;
                        cnt++;
                    end
                end
                if (cnt > 0) begin
                    mq[d][(mt[d] - 1) % 64] += 256;
                end else begin
`ifdef ENC_ZERO_ERR_EN
                    mq[d][mt[d] % 64] = 256 + 512;
                    mt[d]++;
`endif
                end
                if (d == 0) acc_cyc_a.push_back(cyc);
            end
        end
    endtask

    // Compare process: mid-cycle, after all inputs and outputs have settled.
    always @(negedge clk) begin
        cyc++;
        chk(0, ov_a, ir_a, int'(idx_a), last_a, busy_a, err_a, iv_a, {8'h00, in_vec[7:0]}, 8, 0);
        chk(1, ov_b, ir_b, int'(idx_b), last_b, busy_b, err_b, iv_b, in_vec, 16, 0);
        chk(2, ov_c, ir_c, int'(idx_c), last_c, busy_c, err_c, iv_c, {8'h00, in_vec[7:0]}, 8, 1);
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? ir_a : (d == 1) ? ir_b : ir_c;
    endfunction

    // Present a vector to instance d and hold it until the handshake completes.
    task automatic send(input int d, input logic [15:0] v);
        int k;
        in_vec = v;
        iv_a = (d == 0);
        iv_b = (d == 1);
        iv_c = (d == 2);
        k = 0;
        while (!rdy(d) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: in_ready never rose, got 0, expected 1");
        end else begin
            @(posedge clk); #1;
        end
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((mt[0] != mh[0] || mt[1] != mh[1] || mt[2] != mh[2]) && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 100) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: beats still pending, got %0d, expected 0", mt[0] - mh[0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_logs();
        loga.delete(); logb.delete(); logc.delete();
        acc_cyc_a.delete(); beat_cyc_a.delete();
    endtask

    initial begin
        int e3a[3];
        int e3c[3];
        int e4[4];
        e3a = '{2, 5, 7};
        e3c = '{7, 5, 2};
        e4  = '{2, 5, 7, 0};
        for (int d = 0; d < 3; d++) begin mh[d] = 0; mt[d] = 0; end
        rst_n = 1'b1; out_ready = 1'b1; in_vec = '0;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 ck("release_in_ready", ir_a, 1);

        // one-hot sweep: single beat each, idx 0..7
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            send(0, 16'(1 << i));
            wait_idle();
        end
        ck("sweep_count", loga.size(), 8);
        for (int i = 0; i < 8; i++) ck("sweep_idx", loga[i], i);

        // multi-bit vector with back-to-back reload on the last beat
        clear_logs();
        send(0, 16'h00A4);
        send(0, 16'h0001);
        wait_idle();
        ck("b2b_count", loga.size(), 4);
        for (int i = 0; i < 4; i++) ck("b2b_idx", loga[i], e4[i]);
        ck("b2b_reload_cycle", acc_cyc_a[1], beat_cyc_a[2]);

        // MSB-first ordering
        clear_logs();
        send(2, 16'h00A4);
        wait_idle();
        ck("msb_count", logc.size(), 3);
        for (int i = 0; i < 3; i++) ck("msb_idx", logc[i], e3c[i]);

        // backpressure on the first beat for 3 cycles
        clear_logs();
        out_ready = 1'b0;
        send(0, 16'h00A4);
        repeat (3) begin
            ck("bp_idx_held", idx_a, 2);
            ck("bp_valid_held", ov_a, 1);
            ck("bp_in_ready", ir_a, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_idle();
        ck("bp_count", loga.size(), 3);
        for (int i = 0; i < 3; i++) ck("bp_idx", loga[i], e3a[i]);

        // zero vector
        clear_logs();
        send(0, 16'h0000);
`ifdef ENC_ZERO_ERR_EN
        ck("zero_err", err_a, 1);
        ck("zero_last", last_a, 1);
        wait_idle();
        ck("zero_count", loga.size(), 1);
        ck("zero_idx", loga[0], 0);
`else
        ck("zero_busy", busy_a, 0);
        ck("zero_valid", ov_a, 0);
        wait_idle();
        ck("zero_count", loga.size(), 0);
`endif

        // 16-bit extremes
        clear_logs();
        send(1, 16'h8001);
        wait_idle();
        ck("w16_count", logb.size(), 2);
        ck("w16_first", logb[0], 0);
        ck("w16_second", logb[1], 15);

        // reset after the first beat: nothing further afterwards
        clear_logs();
        send(1, 16'h00FF);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 ck("midrst_valid", ov_b, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        ck("midrst_count", logb.size(), 1);
        ck("midrst_first", logb[0], 0);
        ck("midrst_idle", ov_b, 0);

        // reset mid-drain on the 8-bit instance, then traffic again
        clear_logs();
        send(0, 16'h00F0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1 ck("rst2_in_ready", ir_a, 1);
        send(0, 16'h0081);
        wait_idle();
        ck("rst2_last_beat", loga[loga.size() - 1], 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
